// File: rtl/adder_arb_pkg.sv
// Shared types for the adder arbiter: opcodes, FSM states and index helpers.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_CLEAR = 2'b01,
    OP_LOAD  = 2'b10,
    OP_READ  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RSP  = 2'd2
  } state_t;

  // Wide enough for up to four requesters.
  localparam int IDX_W = 2;

  function automatic logic [3:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin picker: first request above the pointer, wrapping.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int   cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/adder_arbiter.sv
// Time-shares one external adder and a DATA_WIDTH+1 bit accumulator between
// NUM_REQ requesters: accept, execute for one cycle, then hold the response.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*2-1:0]          req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH:0]           rsp_data,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  output logic                          add_cin,
  input  logic [DATA_WIDTH-1:0]         add_s,
  input  logic                          add_cout,
  output logic [DATA_WIDTH:0]           acc_q,
  output logic                          busy
);

  state_t                  state_q;
  op_t                     op_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [IDX_W-1:0]        grant_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH:0]     acc_d;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  op_t                     sel_op;
  logic [DATA_WIDTH-1:0]   sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign sel_op   = op_t'(req_op[int'(arb_idx)*2 +: 2]);
  assign sel_data = req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Ready is offered only while idle and out of reset, so nothing handshakes during reset.
  assign req_ready = (state_q == IDLE && reset) ? arb_grant : '0;

  assign add_a     = (state_q == EXEC) ? data_q : '0;
  assign add_b     = (state_q == EXEC) ? acc_q[DATA_WIDTH-1:0] : '0;
  assign add_cin   = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = acc_q;
  assign busy      = (state_q != IDLE);

  // The old carry in acc_q[DATA_WIDTH] never feeds back; an ADD replaces it.
  always_comb begin
    acc_d = acc_q;
    case (op_q)
      OP_ADD:   acc_d = {add_cout, add_s};
      OP_CLEAR: acc_d = '0;
      OP_LOAD:  acc_d = {1'b0, data_q};
      OP_READ:  acc_d = acc_q;
      default:  acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      data_q      <= '0;
      grant_q     <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      rsp_valid_q <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            op_q    <= sel_op;
            data_q  <= sel_data;
            grant_q <= arb_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          acc_q       <= acc_d;
          rsp_valid_q <= NUM_REQ'(idx_to_onehot(grant_q));
          state_q     <= RSP;
        end
        RSP: begin
          if (rsp_ready[grant_q]) begin
            ptr_q       <= grant_q;
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized checks of adder_arbiter against a behavioural accumulator model.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int DW = 16;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     reqValid;
  logic [NR-1:0]     reqReady;
  logic [2*NR-1:0]   reqOp;
  logic [NR*DW-1:0]  reqData;
  logic [NR-1:0]     rspValid;
  logic [NR-1:0]     rspReady;
  logic [DW:0]       rspData;
  logic [DW-1:0]     addA;
  logic [DW-1:0]     addB;
  logic              addCin;
  logic [DW-1:0]     addS;
  logic              addCout;
  logic [DW:0]       accQ;
  logic              busy;

  int vectors    = 0;
  int miscompares = 0;
  int unsigned modelAcc = 0;
  int lastWinner = NR - 1;

  adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_op    (reqOp),
    .req_data  (reqData),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_data  (rspData),
    .add_a     (addA),
    .add_b     (addB),
    .add_cin   (addCin),
    .add_s     (addS),
    .add_cout  (addCout),
    .acc_q     (accQ),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // External adder modelled as a plain sum.
  assign {addCout, addS} = {1'b0, addA} + {1'b0, addB} + {16'b0, addCin};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int r, input logic v, input op_t op, input logic [DW-1:0] d);
    reqValid[r]          = v;
    reqOp[2*r +: 2]      = op;
    reqData[DW*r +: DW]  = d;
  endtask

  task automatic modelApply(input op_t op, input int unsigned d);
    case (op)
      OP_ADD:   modelAcc = ((modelAcc & 32'hFFFF) + d) & 32'h1FFFF;
      OP_CLEAR: modelAcc = 0;
      OP_LOAD:  modelAcc = d & 32'hFFFF;
      default:  modelAcc = modelAcc;
    endcase
  endtask

  function automatic int rrPick(input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(lastWinner + k) % NR]) return (lastWinner + k) % NR;
    end
    return -1;
  endfunction

  // One full transaction, starting in IDLE with requests already driven.
  task automatic serveOne(input int expR, input int hold, input logic keepValid, input logic [NR-1:0] lateValid);
    op_t op;
    logic [DW-1:0] d;
    logic [NR-1:0] expOneHot;
    op = op_t'(reqOp[2*expR +: 2]);
    d = reqData[DW*expR +: DW];
    expOneHot = NR'(1) << expR;
    #1;
    checkOutput("req_ready_grant", 32'(reqReady), 32'(expOneHot));
    checkOutput("busy_idle", 32'(busy), 32'd0);
    rspReady = (hold > 0) ? ~expOneHot : '1;
    stepClk();
    if (!keepValid) reqValid[expR] = 1'b0;
    reqValid = reqValid | lateValid;
    #1;
    checkOutput("busy_exec", 32'(busy), 32'd1);
    checkOutput("req_ready_exec", 32'(reqReady), 32'd0);
    checkOutput("add_a", 32'(addA), 32'(d));
    checkOutput("add_b", 32'(addB), modelAcc & 32'hFFFF);
    checkOutput("add_cin", 32'(addCin), 32'd0);
    checkOutput("rsp_valid_exec", 32'(rspValid), 32'd0);
    modelApply(op, 32'(d));
    stepClk();
    checkOutput("rsp_valid", 32'(rspValid), 32'(expOneHot));
    checkOutput("rsp_data", 32'(rspData), modelAcc);
    checkOutput("acc_q", 32'(accQ), modelAcc);
    for (int i = 0; i < hold; i++) begin
      stepClk();
      checkOutput("rsp_valid_hold", 32'(rspValid), 32'(expOneHot));
      checkOutput("rsp_data_hold", 32'(rspData), modelAcc);
      checkOutput("busy_hold", 32'(busy), 32'd1);
      checkOutput("req_ready_hold", 32'(reqReady), 32'd0);
    end
    rspReady = '1;
    stepClk();
    checkOutput("busy_back_idle", 32'(busy), 32'd0);
    checkOutput("rsp_valid_idle", 32'(rspValid), 32'd0);
    lastWinner = expR;
  endtask

  initial begin
    int pick;
    logic [NR-1:0] v;
    reset    = 1'b0;
    reqValid = '0;
    reqOp    = '0;
    reqData  = '0;
    rspReady = '0;
    stepClk();
    stepClk();
    checkOutput("reset_acc", 32'(accQ), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset_add_a", 32'(addA), 32'd0);
    checkOutput("reset_add_b", 32'(addB), 32'd0);
    applyStimulus(0, 1'b1, OP_LOAD, 16'h1234);
    #1;
    checkOutput("reset_req_ready", 32'(reqReady), 32'd0);
    stepClk();
    reset = 1'b1;

    serveOne(0, 0, 1'b0, '0);
    checkOutput("load_value", 32'(accQ), 32'h01234);

    applyStimulus(0, 1'b1, OP_LOAD, 16'h0001);
    serveOne(0, 0, 1'b0, '0);
    applyStimulus(0, 1'b1, OP_ADD, 16'hFFFF);
    serveOne(0, 0, 1'b0, '0);
    checkOutput("carry_out", 32'(accQ), 32'h10000);
    applyStimulus(0, 1'b1, OP_ADD, 16'h0001);
    serveOne(0, 0, 1'b0, '0);
    checkOutput("carry_dropped", 32'(accQ), 32'h00001);

    applyStimulus(1, 1'b1, OP_LOAD, 16'h0000);
    serveOne(1, 0, 1'b0, '0);
    applyStimulus(0, 1'b1, OP_ADD, 16'h0001);
    applyStimulus(1, 1'b1, OP_ADD, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      serveOne(k % 2, 0, 1'b1, '0);
      checkOutput("fair_result", 32'(accQ), 32'(k + 1));
    end
    reqValid = '0;

    applyStimulus(1, 1'b1, OP_READ, 16'h5555);
    applyStimulus(0, 1'b0, OP_READ, 16'h0000);
    serveOne(1, 5, 1'b0, 2'b01);
    serveOne(0, 0, 1'b0, '0);

    applyStimulus(0, 1'b1, OP_LOAD, 16'hABCD);
    serveOne(0, 0, 1'b0, '0);
    applyStimulus(0, 1'b1, OP_CLEAR, 16'h7777);
    serveOne(0, 0, 1'b0, '0);
    checkOutput("clear_result", 32'(accQ), 32'd0);
    applyStimulus(0, 1'b1, OP_ADD, 16'h0005);
    serveOne(0, 0, 1'b0, '0);
    checkOutput("add_after_clear", 32'(accQ), 32'h00005);

    applyStimulus(0, 1'b1, OP_LOAD, 16'h00FF);
    serveOne(0, 0, 1'b0, '0);
    applyStimulus(0, 1'b1, OP_ADD, 16'h0010);
    #1;
    stepClk();
    reqValid = '0;
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_acc", 32'(accQ), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_add_a", 32'(addA), 32'd0);
    stepClk();
    checkOutput("mid_reset_rsp_valid", 32'(rspValid), 32'd0);
    reset = 1'b1;
    modelAcc = 0;
    lastWinner = NR - 1;
    stepClk();
    checkOutput("post_reset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("post_reset_acc", 32'(accQ), 32'd0);

    applyStimulus(1, 1'b1, OP_ADD, 16'h0003);
    serveOne(1, 0, 1'b0, '0);
    applyStimulus(0, 1'b1, OP_ADD, 16'h0004);
    applyStimulus(1, 1'b1, OP_ADD, 16'h0008);
    serveOne(0, 0, 1'b0, '0);
    serveOne(1, 0, 1'b0, '0);
    checkOutput("post_reset_sum", 32'(accQ), 32'h0000F);

    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < NR; r++) begin
        applyStimulus(r, 1'($urandom_range(0, 1)), op_t'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
      end
      if (reqValid == '0) reqValid[$urandom_range(0, NR-1)] = 1'b1;
      v = reqValid;
      pick = rrPick(v);
      serveOne(pick, int'($urandom_range(0, 2)), 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one external DATA_WIDTH-bit adder and a single accumulator register between NUM_REQ requesters, for example switch-input logic and a future UART or auto-sequencer.
- Each request carries an opcode and operand. The block arbitrates round-robin, drives the shared adder for one cycle, updates the accumulator and returns the new value to the granted requester.
- Sits between the requesters and the ripple/lookahead/select adder instance. The accumulator output feeds the hex display and the sign LED.

Parameters:
- DATA_WIDTH, 16, operand and adder width. The accumulator is DATA_WIDTH+1 bits wide.
- NUM_REQ, 2, number of requesters. Legal range is 2..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept. At most one bit is high at a time.
- req_op  in  NUM_REQ*2  per-requester opcode (op_t), packed with requester 0 in the LSBs.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester operand, packed the same way.
- rsp_valid  out  NUM_REQ  response valid to the granted requester.
- rsp_ready  in  NUM_REQ  requester accepts the response.
- rsp_data  out  DATA_WIDTH+1  accumulator value, shared by all requesters.
- add_a  out  DATA_WIDTH  shared adder operand a.
- add_b  out  DATA_WIDTH  shared adder operand b.
- add_cin  out  1  shared adder carry-in. Always 0.
- add_s  in  DATA_WIDTH  shared adder sum.
- add_cout  in  1  shared adder carry-out.
- acc_q  out  DATA_WIDTH+1  live accumulator value for display. Bit DATA_WIDTH drives sign_led.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, acc=0, grant index=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - req_ready, rsp_valid, add_a, add_b and busy are all 0.
  - An in-flight operation or pending response is discarded with no response.
- State machine: IDLE -> EXEC -> RSP -> IDLE.
- IDLE:
  - Selection is round-robin: the first req_valid bit found scanning upward from pointer+1, with wrap-around.
  - req_ready[g] is asserted combinationally in the same cycle for the selected g only.
  - On valid&ready, latch op_q=req_op[g], data_q=req_data[g] and g, then go to EXEC.
  - With no req_valid bit set, the block stays in IDLE and all outputs stay quiet.
- EXEC (exactly 1 cycle):
  - Drive add_a=data_q, add_b=acc[DATA_WIDTH-1:0], add_cin=0.
  - Outside EXEC, add_a and add_b are 0.
  - At the clock edge, update the accumulator by opcode:
    - OP_ADD: acc <= {add_cout, add_s}.
    - OP_CLEAR: acc <= 0.
    - OP_LOAD: acc <= {1'b0, data_q}.
    - OP_READ: acc unchanged.
  - Go to RSP.
- RSP:
  - rsp_valid[g]=1 and rsp_data=acc, both held stable until rsp_ready[g]=1.
  - On the handshake: pointer <= g, then go to IDLE.
  - rsp_ready on non-granted bits is ignored.
  - New req_valid bits are not accepted while in RSP.
- Latency and throughput:
  - Accept in cycle T, accumulator updated at the end of T+1, rsp_valid high from T+2.
  - Maximum throughput is 1 operation per 3 cycles with rsp_ready tied high.
- Width rules:
  - The carry of an ADD is kept in acc[DATA_WIDTH].
  - A following ADD uses only acc[DATA_WIDTH-1:0] as operand b. The carry bit is overwritten by the new add_cout, not accumulated.
- Fairness:
  - A requester that holds req_valid continuously is served within NUM_REQ operations.
  - Dropping req_valid before acceptance is legal and leaves no side effect.
- Simultaneous events:
  - Two requesters valid in the same cycle: the round-robin winner is accepted. The other keeps req_ready=0 and must hold its request.
  - Reset asserted during EXEC: the accumulator is forced to 0 whatever the adder outputs are.

Decomposition:
- Package adder_arb_pkg:
  - op_t as a 2-bit enum: OP_ADD=2'b00, OP_CLEAR=2'b01, OP_LOAD=2'b10, OP_READ=2'b11.
  - state_t enum: IDLE, EXEC, RSP.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant plus binary index.
  - Purely combinational. The pointer register lives in adder_arbiter.

Test Plan:
- Reset, then req0 OP_LOAD 0x1234 -> req_ready[0] in the same cycle. rsp_valid[0] 2 cycles later with rsp_data=0x01234 and acc_q=0x01234.
- Req0 OP_ADD 0xFFFF with acc=0x00001 -> add_a=0xFFFF and add_b=0x0001 during EXEC. Response 0x10000, acc_q[16]=1.
- Req0 and req1 both valid continuously with OP_ADD 0x0001 from acc=0 -> grant order 0,1,0,1. Responses 0x00001, 0x00002, 0x00003, 0x00004.
- Hold rsp_ready[1]=0 for 5 cycles after a req1 OP_READ -> rsp_valid[1] and rsp_data stay stable. busy=1, req_ready=0 despite req0 valid. Release -> IDLE next cycle, then req0 is granted.
- Req0 OP_CLEAR after acc=0x0ABCD -> response 0x00000. A following OP_ADD 0x0005 gives 0x00005.
- Assert reset in EXEC of an OP_ADD 0x0010 -> acc_q=0 immediately, no rsp_valid. After release, req1 alone is valid -> granted, and the pointer reset is checked by then making both requesters valid.
